hilo_muldiv_seq: RTL and testbench

Iterative multiply/divide sequencer that owns all writes to the register file's HI/LO pair. It accepts one MULT/MULTU/DIV/DIVU request from decode and runs a 32-step shift-add or restoring-divide loop. It then presents the 64-bit result with one-cycle HiWrite/LoWrite strobes. It also produces the stall that holds the core while an instruction wants HI/LO and the unit is busy.

---
 rtl/hilo_muldiv_seq_pkg.sv | 28 ++
 rtl/hilo_muldiv_seq_sign_fix.sv | 34 +++
 rtl/hilo_muldiv_seq.sv | 146 ++++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
package hilo_pkg;

  localparam int HILO_WIDTH = 32;
  localparam int HILO_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_muldiv_seq_sign_fix.sv
// Conditional two's-complement negation of a value pair, either as one
// 2*W-bit quantity (joint_i) or as two independent W-bit halves.
module hilo_sign_fix #(
  parameter int W = 32
) (
  input  logic         joint_i,
  input  logic         neg_hi_i,
  input  logic         neg_lo_i,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [2*W-1:0] pair_neg;
  logic [W-1:0]   hi_neg;
  logic [W-1:0]   lo_neg;

  assign pair_neg = -{hi_i, lo_i};
  assign hi_neg   = -hi_i;
  assign lo_neg   = -lo_i;

  always_comb begin
    hi_o = hi_i;
    lo_o = lo_i;
    if (joint_i) begin
      if (neg_hi_i) {hi_o, lo_o} = pair_neg;
    end else begin
      if (neg_hi_i) hi_o = hi_neg;
      if (neg_lo_i) lo_o = lo_neg;
    end
  end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning all HI/LO writes.
//   state  | meaning
//   S_IDLE | waiting for start; flush blocks acceptance
//   S_CALC | one shift-add / restoring-divide step per cycle
//   S_DONE | result fixup registered onto the write strobes
module hilo_muldiv_seq
  import hilo_pkg::*;
#(
  parameter int WIDTH = HILO_WIDTH,
  parameter int CNT_W = HILO_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             hilo_use,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic             hi_we,
  output logic             lo_we,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q;
  logic               is_div_q, neg_res_q, neg_rem_q, dz_q;
  logic               done_q, div_zero_q, we_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               sgn_op, div_op;
  logic [WIDTH-1:0]   mag_a, mag_b, res_hi, res_lo;
  logic [WIDTH:0]     mul_sum, div_diff;

  assign sgn_op = op_is_signed(op);
  assign div_op = op_is_div(op);

  hilo_sign_fix #(.W(WIDTH)) u_opnd_fix (
    .joint_i  (1'b0),
    .neg_hi_i (sgn_op & src_a[WIDTH-1]),
    .neg_lo_i (sgn_op & src_b[WIDTH-1]),
    .hi_i     (src_a),
    .lo_i     (src_b),
    .hi_o     (mag_a),
    .lo_o     (mag_b)
  );

  // Products negate as one 2*WIDTH value; quotient/remainder negate separately.
  hilo_sign_fix #(.W(WIDTH)) u_res_fix (
    .joint_i  (~is_div_q),
    .neg_hi_i (is_div_q ? neg_rem_q : neg_res_q),
    .neg_lo_i (neg_res_q),
    .hi_i     (acc_q[2*WIDTH-1:WIDTH]),
    .lo_i     (acc_q[WIDTH-1:0]),
    .hi_o     (res_hi),
    .lo_o     (res_lo)
  );

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, m_q};
    acc_d    = acc_q;
    if (is_div_q) begin
      if (div_diff[WIDTH]) acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      else                 acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      m_q        <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      we_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      we_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            is_div_q  <= div_op;
            neg_res_q <= sgn_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem_q <= sgn_op & src_a[WIDTH-1];
            dz_q      <= div_op && (src_b == '0);
            acc_q     <= {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
            m_q       <= div_op ? mag_b : mag_a;
            cnt_q     <= '0;
            state_q   <= S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          if (!flush) begin
            done_q     <= 1'b1;
            div_zero_q <= dz_q;
            if (!dz_q) begin
              we_q <= 1'b1;
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign stall    = hilo_use & busy & ~done_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi_we    = we_q;
  assign lo_we    = we_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Self-checking bench for hilo_muldiv_seq: vector table, random model checks
// and hand-written flush/reset/restart sequences.
module tb_hilo_muldiv_seq;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        hilo_use = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, stall, done, div_zero, hi_we, lo_we;
  logic [31:0] hi_out, lo_out;

  int total = 0;
  int bad = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          we;
    bit          dz;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[11];

  always #5 clk = ~clk;

  hilo_muldiv_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .hilo_use (hilo_use),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div_zero (div_zero),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sbv, q, r;
    longint unsigned ua, ub, p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    e.we = 1'b1;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (o)
      OP_MULTU: begin p = ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; end
      OP_MULT:  begin q = sa * sbv; e.hi = q[63:32]; e.lo = q[31:0]; end
      OP_DIVU:  begin p = ua / ub; e.lo = p[31:0]; p = ua % ub; e.hi = p[31:0]; end
      default:  begin q = sa / sbv; r = sa % sbv; e.lo = q[31:0]; e.hi = r[31:0]; end
    endcase
    return e;
  endfunction

  // Enters and leaves at 1ns after a rising edge.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int restart_at, input bit use_hl, input bit b2b);
    int k, busy_cnt, stall_miss;
    bit seen;
    exp_t x;
    sbq.push_back(e);
    start = 1'b1; op = o; src_a = a; src_b = b; hilo_use = use_hl;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; busy_cnt = 0; stall_miss = 0; seen = 1'b0;
    while (!seen && k <= 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cnt++;
        if (use_hl && busy && stall !== 1'b1) stall_miss++;
        start = (k == restart_at);
        if (start) begin op = OP_MULTU; src_a = 32'h5; src_b = 32'h9; end
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    x = sbq.pop_front();
    if (!seen) begin
      chk("done_timeout", 64'(k), 64'(33));
    end else begin
      chk("latency", 64'(k), 64'(33));
      chk("busy_cycles", 64'(busy_cnt), 64'(33));
      chk("busy_at_done", 64'(busy), 64'(0));
      chk("stall_at_done", 64'(stall), 64'(0));
      chk("div_zero", 64'(div_zero), 64'(x.dz));
      chk("hi_we", 64'(hi_we), 64'(x.we));
      chk("lo_we", 64'(lo_we), 64'(x.we));
      if (x.we) begin
        chk("hi_out", 64'(hi_out), 64'(x.hi));
        chk("lo_out", 64'(lo_out), 64'(x.lo));
        last_hi = x.hi;
        last_lo = x.lo;
      end else begin
        chk("hi_held", 64'(hi_out), 64'(last_hi));
        chk("lo_held", 64'(lo_out), 64'(last_lo));
      end
    end
    if (use_hl) chk("stall_while_busy", 64'(stall_miss), 64'(0));
    hilo_use = 1'b0;
    if (!b2b) begin
      @(posedge clk); #1;
      chk("done_pulse_width", 64'({done, hi_we, lo_we}), 64'(0));
    end
  endtask

  task automatic kick(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[6]  = '{OP_DIVU,  32'd100,      32'd0,        32'h0,        32'h0,        1'b1};
    vecs[7]  = '{OP_MULT,  32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hEDCBA988, 1'b0};
    vecs[8]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vecs[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};

    hilo_use = 1'b1;
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stall", 64'(stall), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_flags", 64'({div_zero, hi_we, lo_we}), 64'(0));
    chk("rst_hi_lo", {hi_out, lo_out}, 64'(0));
    hilo_use = 1'b0;
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // dz vector runs back-to-back: next start lands in the done cycle.
    for (int i = 0; i < 11; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b,
             exp_t'{vecs[i].hi, vecs[i].lo, !vecs[i].dz, vecs[i].dz}, -1, 1'b0, vecs[i].dz);

    for (int i = 0; i < 4; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (op_is_div(ro) && rb == 32'h0) rb = 32'h1;
      run_op(ro, ra, rb, model(ro, ra, rb), -1, 1'b0, 1'b0);
    end

    // restart ignored while busy, stall held until completion
    run_op(OP_MULT, 32'hFFFFFFF6, 32'd12, exp_t'{32'hFFFFFFFF, 32'hFFFFFF88, 1'b1, 1'b0}, 5, 1'b1, 1'b0);
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (done || hi_we) n++; end
    chk("no_extra_done", 64'(n), 64'(0));

    // flush in CALC
    kick(OP_MULTU, 32'd3, 32'd4);
    repeat (10) begin @(posedge clk); #1; end
    chk("busy_before_flush", 64'(busy), 64'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_calc_idle", 64'(busy), 64'(0));
    n = 0;
    repeat (40) begin @(posedge clk); #1; if (done || hi_we || lo_we) n++; end
    chk("flush_calc_no_done", 64'(n), 64'(0));
    chk("flush_calc_hi_held", {hi_out, lo_out}, {last_hi, last_lo});

    // flush in DONE
    kick(OP_DIVU, 32'd9, 32'd3);
    repeat (32) begin @(posedge clk); #1; end
    chk("busy_in_done", 64'(busy), 64'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_strobes", 64'({done, hi_we, lo_we}), 64'(0));
    chk("flush_done_idle", 64'(busy), 64'(0));
    chk("flush_done_hi_held", {hi_out, lo_out}, {last_hi, last_lo});

    // flush in IDLE blocks start
    flush = 1'b1;
    kick(OP_MULTU, 32'd1, 32'd1);
    flush = 1'b0;
    chk("flush_blocks_start", 64'(busy), 64'(0));

    // reset mid-operation
    kick(OP_MULTU, 32'd7, 32'd8);
    repeat (20) begin @(posedge clk); #1; end
    chk("busy_before_rst", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_strobes", 64'({done, hi_we, lo_we}), 64'(0));
    chk("rst_mid_hi_lo", {hi_out, lo_out}, 64'(0));
    last_hi = '0;
    last_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(OP_MULTU, 32'd2, 32'd3, exp_t'{32'h0, 32'h6, 1'b1, 1'b0}, -1, 1'b0, 1'b0);

    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
